// File: rtl/temp_seg7_display.sv
// Temperature display: DS18B20 word -> sign + BCD digits -> multiplexed N-digit seven-segment pins.
// Latency: 24 cycles from an accepted temp_valid to the buffer update; seg/sel follow one cycle later.
// No backpressure: strobes during a conversion land in a one-deep pending slot (newest wins). Option macro: TEMP_SEG7_ALARM_EN.
module temp_seg7_display #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int DIGITS         = 4,
  parameter int SCAN_HZ        = 1000,
  parameter int FRAC_DIGITS    = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       temp_raw,
  input  logic              temp_valid,
`ifdef TEMP_SEG7_ALARM_EN
  input  logic [15:0]       alarm_thresh,
  output logic              alarm,
`endif
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] sel,
  output logic              busy,
  output logic              overflow
);

  localparam int DWELL = (CLK_HZ / SCAN_HZ > 0) ? CLK_HZ / SCAN_HZ : 1;
  localparam int PW    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int IW    = $clog2(DIGITS);

  localparam logic [7:0]        SEG_MINUS = 8'h40;
  localparam logic [7:0]        SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] SEL_OFF   = (SEL_ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [2:0] {S_IDLE, S_ABS, S_BINT, S_BFRAC, S_LOAD} state_t;

  state_t state_q, state_d;

  logic [15:0] raw_q;
  logic        pend_vld_q;
  logic [15:0] pend_dat_q;
  logic        sign_q;
  logic        mag_nz_q;
  logic        mag_hi_q;
  logic [13:0] fr_q;
  logic [13:0] bin_q;
  logic [15:0] bcd_q;
  logic [11:0] int_bcd_q;
  logic [3:0]  cnt_q;

  logic [DIGITS-1:0][7:0] disp_q, disp_d;
  logic                   ovf_q, ovf_d;
  logic                   neg;
  int                     n_int;

  logic [15:0] mag_calc;
  logic [13:0] fr_calc;
  logic [15:0] bcd_adj;
  logic [15:0] bcd_shift;

  logic [PW-1:0]     presc_q;
  logic [IW-1:0]     idx_q;
  logic [7:0]        seg_q;
  logic [DIGITS-1:0] sel_q;
  logic [DIGITS-1:0] sel_onehot;
  logic              sel_blank;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'h3F;
      4'd1:    seg_code = 8'h06;
      4'd2:    seg_code = 8'h5B;
      4'd3:    seg_code = 8'h4F;
      4'd4:    seg_code = 8'h66;
      4'd5:    seg_code = 8'h6D;
      4'd6:    seg_code = 8'h7D;
      4'd7:    seg_code = 8'h07;
      4'd8:    seg_code = 8'h7F;
      4'd9:    seg_code = 8'h6F;
      default: seg_code = 8'h00;
    endcase
  endfunction

  function automatic logic [15:0] dd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // 0x8000 negates to itself, which lands in the overflow range as intended.
  assign mag_calc  = raw_q[15] ? (~raw_q + 16'd1) : raw_q;
  assign fr_calc   = 14'(mag_calc[3:0]) * 14'd625;
  assign bcd_adj   = dd_adjust(bcd_q);
  assign bcd_shift = {bcd_adj[14:0], bin_q[13]};

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (temp_valid) state_d = S_ABS;
      S_ABS:   state_d = S_BINT;
      S_BINT:  if (cnt_q == 4'd7) state_d = S_BFRAC;
      S_BFRAC: if (cnt_q == 4'd13) state_d = S_LOAD;
      S_LOAD:  state_d = (pend_vld_q || temp_valid) ? S_ABS : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      raw_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_dat_q <= '0;
      sign_q     <= 1'b0;
      mag_nz_q   <= 1'b0;
      mag_hi_q   <= 1'b0;
      fr_q       <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      int_bcd_q  <= '0;
      cnt_q      <= '0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (temp_valid && state_q != S_IDLE) begin
        pend_vld_q <= 1'b1;
        pend_dat_q <= temp_raw;
      end
      case (state_q)
        S_IDLE: if (temp_valid) raw_q <= temp_raw;
        S_ABS: begin
          sign_q   <= raw_q[15];
          mag_nz_q <= |mag_calc;
          mag_hi_q <= |mag_calc[15:12];
          fr_q     <= fr_calc;
          bin_q    <= {mag_calc[11:4], 6'b0};
          bcd_q    <= '0;
          cnt_q    <= '0;
        end
        S_BINT: begin
          if (cnt_q == 4'd7) begin
            // Integer part done; reuse the shifter for the fraction.
            int_bcd_q <= bcd_shift[11:0];
            bcd_q     <= '0;
            bin_q     <= fr_q;
            cnt_q     <= '0;
          end else begin
            bcd_q <= bcd_shift;
            bin_q <= {bin_q[12:0], 1'b0};
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_BFRAC: begin
          bcd_q <= bcd_shift;
          bin_q <= {bin_q[12:0], 1'b0};
          cnt_q <= cnt_q + 4'd1;
        end
        S_LOAD: begin
          disp_q <= disp_d;
          ovf_q  <= ovf_d;
          // A strobe in this very cycle is newer than anything pending.
          if (temp_valid || pend_vld_q) begin
            raw_q      <= temp_valid ? temp_raw : pend_dat_q;
            pend_vld_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    disp_d = '0;
    neg    = sign_q && mag_nz_q;
    if (int_bcd_q[11:8] != 4'd0)     n_int = 3;
    else if (int_bcd_q[7:4] != 4'd0) n_int = 2;
    else                             n_int = 1;
    ovf_d = mag_hi_q || ((int'(neg) + n_int + FRAC_DIGITS) > DIGITS);
    for (int p = 0; p < DIGITS; p++) begin
      if (ovf_d) begin
        disp_d[p] = SEG_MINUS;
      end else if (p < FRAC_DIGITS) begin
        // Fraction BCD holds four digits; keep the top FRAC_DIGITS of them.
        disp_d[p] = seg_code(4'(bcd_q >> (4 * (4 - FRAC_DIGITS + p))));
      end else if ((p - FRAC_DIGITS) < n_int) begin
        disp_d[p] = seg_code(4'(int_bcd_q >> (4 * (p - FRAC_DIGITS))));
        if (FRAC_DIGITS > 0 && p == FRAC_DIGITS) disp_d[p][7] = 1'b1;
      end else if (neg && (p - FRAC_DIGITS) == n_int) begin
        disp_d[p] = SEG_MINUS;
      end
    end
  end

`ifdef TEMP_SEG7_ALARM_EN
  localparam int HALF = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic          alarm_q;
  logic          alarm_hit;
  logic          blink_off_q;
  logic [BW-1:0] blink_cnt_q;

  assign alarm_hit = $signed(raw_q) >= $signed(alarm_thresh);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alarm_q     <= 1'b0;
      blink_off_q <= 1'b0;
      blink_cnt_q <= '0;
    end else begin
      if (state_q == S_LOAD) alarm_q <= alarm_hit;
      if (state_q == S_LOAD && alarm_hit && !alarm_q) begin
        blink_cnt_q <= '0;
        blink_off_q <= 1'b0;
      end else if (blink_cnt_q == BW'(HALF - 1)) begin
        blink_cnt_q <= '0;
        blink_off_q <= ~blink_off_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end
    end
  end

  assign alarm     = alarm_q;
  assign sel_blank = alarm_q & blink_off_q;
`else
  assign sel_blank = 1'b0;
`endif

  assign sel_onehot = DIGITS'(1) << idx_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_OFF;
      sel_q   <= SEL_OFF;
    end else begin
      if (presc_q == PW'(DWELL - 1)) begin
        presc_q <= '0;
        idx_q   <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end else begin
        presc_q <= presc_q + PW'(1);
      end
      seg_q <= (SEG_ACTIVE_LOW != 0) ? ~disp_q[idx_q] : disp_q[idx_q];
      if (sel_blank)                 sel_q <= SEL_OFF;
      else if (SEL_ACTIVE_LOW != 0)  sel_q <= ~sel_onehot;
      else                           sel_q <= sel_onehot;
    end
  end

  assign seg      = seg_q;
  assign sel      = sel_q;
  assign busy     = (state_q != S_IDLE);
  assign overflow = ovf_q;

endmodule
